// File: rtl/bsram_fifo.sv
// ---------------------------------------------------------------------------
// bsram_fifo
//   Single-clock first-word-fall-through FIFO on top of one dual-port block
//   RAM (dpram_block).
//
//   The RAM is split by role:
//   - Port A is the write side.
//   - Port B is the read side.
//
//   The FIFO owns the read end of the RAM. Whenever the output slot is free,
//   or is being popped this cycle, it fetches the next stored word. That word
//   appears on rd_data straight from the RAM output register.
//
//   Ports
//     clk        single clock for the FIFO and both RAM ports
//     reset      asynchronous, active-high reset (RAM contents untouched)
//     wr_en      push wr_data this cycle (ignored while full)
//     wr_data    word to push
//     full       RAM holds DEPTH words
//     rd_en      pop the head word (ignored while rd_valid=0)
//     rd_data    head word, valid while rd_valid=1
//     rd_valid   rd_data holds a valid head word
//     count      total occupancy = words in RAM + head word (max DEPTH+1)
//     overflow   sticky: push attempted while full
//     underflow  sticky: pop attempted while rd_valid=0
// ---------------------------------------------------------------------------

// Simple dual-port RAM.
//   Ports
//     clk_a, we_a, addr_a, datain_a   write port
//     clk_b, re_b, addr_b, dataout_b  read port; dataout_b is registered
//   The read data is registered on every read enable. The output register is
//   not reset, which matches block-RAM primitives.
module dpram_block #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] datain_a,
    input  logic          clk_b,
    input  logic          re_b,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] dataout_b
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] dout_q;

    // Write port: store datain_a on a write enable.
    always_ff @(posedge clk_a) begin
        if (we_a) begin
            mem_q[addr_a] <= datain_a;
        end
    end

    // Read port: capture the addressed word into the output register.
    always_ff @(posedge clk_b) begin
        if (re_b) begin
            dout_q <= mem_q[addr_b];
        end
    end

    assign dataout_b = dout_q;
endmodule

module bsram_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    if (!(DATA_WIDTH == 4 || DATA_WIDTH == 8 || DATA_WIDTH == 16)) begin : g_bad_data_width
        $error("bsram_fifo: DATA_WIDTH must be 4, 8 or 16");
    end
    if (ADDR_WIDTH > 12 || ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("bsram_fifo: ADDR_WIDTH must be in 1..12");
    end

    // Datapath states.
    // rd_valid and full are decoded from the state rather than held as
    // separate flops. FULL always has rd_valid=1: the head slot is refilled
    // one cycle after the RAM becomes non-empty, long before it can fill.
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,  // no head word
        ST_HEAD   = 2'd1,  // head word only, RAM empty
        ST_STREAM = 2'd2,  // head word plus words in RAM
        ST_FULL   = 2'd3   // RAM holds DEPTH words
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]     mem_count_q, mem_count_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic                    rd_valid_s;
    logic                    full_s;
    logic                    rd_valid_d;
    logic                    push_s;
    logic                    pop_s;
    logic                    issue_s;

    // Output decode of the datapath state.
    always_comb begin
        rd_valid_s = 1'b0;
        full_s     = 1'b0;
        case (state_q)
            ST_EMPTY:  begin rd_valid_s = 1'b0; full_s = 1'b0; end
            ST_HEAD:   begin rd_valid_s = 1'b1; full_s = 1'b0; end
            ST_STREAM: begin rd_valid_s = 1'b1; full_s = 1'b0; end
            ST_FULL:   begin rd_valid_s = 1'b1; full_s = 1'b1; end
            default:   begin rd_valid_s = 1'b0; full_s = 1'b0; end
        endcase
    end

    // Request qualification.
    // A RAM read is issued only while the RAM holds data, so the read address
    // is always an older entry than the one being written this cycle.
    always_comb begin
        push_s  = wr_en & ~full_s;
        pop_s   = rd_en & rd_valid_s;
        issue_s = (mem_count_q != {(ADDR_WIDTH + 1){1'b0}}) & (pop_s | ~rd_valid_s);
    end

    // Pointer, occupancy and sticky-flag next-state.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_count_d = mem_count_q;
        rd_valid_d  = rd_valid_s;

        if (push_s) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (issue_s) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, issue_s})
            2'b10:   mem_count_d = mem_count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   mem_count_d = mem_count_q - (ADDR_WIDTH + 1)'(1);
            default: mem_count_d = mem_count_q;
        endcase

        // An issue refills the head slot even when it is popped on the same edge.
        if (issue_s) begin
            rd_valid_d = 1'b1;
        end else if (pop_s) begin
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_valid_s;
        end

        count_d     = mem_count_d + (ADDR_WIDTH + 1)'(rd_valid_d);
        overflow_d  = overflow_q | (wr_en & full_s);
        underflow_d = underflow_q | (rd_en & ~rd_valid_s);
    end

    // Datapath state next-state from the next occupancy and head validity.
    always_comb begin
        state_d = state_q;
        if (!rd_valid_d) begin
            state_d = ST_EMPTY;
        end else if (mem_count_d == DEPTH_C) begin
            state_d = ST_FULL;
        end else if (mem_count_d == {(ADDR_WIDTH + 1){1'b0}}) begin
            state_d = ST_HEAD;
        end else begin
            state_d = ST_STREAM;
        end
    end

    // State register; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            wptr_q      <= {ADDR_WIDTH{1'b0}};
            rptr_q      <= {ADDR_WIDTH{1'b0}};
            mem_count_q <= {(ADDR_WIDTH + 1){1'b0}};
            count_q     <= {(ADDR_WIDTH + 1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_count_q <= mem_count_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    dpram_block #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk_a     (clk),
        .we_a      (push_s),
        .addr_a    (wptr_q),
        .datain_a  (wr_data),
        .clk_b     (clk),
        .re_b      (issue_s),
        .addr_b    (rptr_q),
        .dataout_b (rd_data)
    );

    assign full      = full_s;
    assign rd_valid  = rd_valid_s;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_bsram_fifo.sv
// ---------------------------------------------------------------------------
// tb_bsram_fifo
//   Directed bench for bsram_fifo (DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16).
//
//   Inputs change on the falling edge. Outputs are sampled 1 time unit after
//   the rising edge.
//
//   Coverage:
//   - A vector table covers first-word latency, pop, underflow and
//     mixed push/pop.
//   - Hand-written sequences cover fill/overflow, drain, long streaming with
//     pointer wrap, and asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_bsram_fifo;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_chk;
    int n_err;

    bsram_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        logic          ev;    // expected rd_valid
        logic [AW:0]   ec;    // expected count
        logic          ef;    // expected full
        logic [DW-1:0] edat;  // expected rd_data (checked only when ev=1)
        logic          eu;    // expected underflow
        logic          eo;    // expected overflow
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and return just after the clock edge.
    task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd);
        @(negedge clk);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp_v;
        logic [DW-1:0] in_v;

        n_chk   = 0;
        n_err   = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;

        //            wr    wd     rd    ev    ec     ef    edat   eu    eo
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vt[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[4] = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[5] = '{1'b1, 8'h3C, 1'b0, 1'b1, 5'd2, 1'b0, 8'h5A, 1'b1, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd1, 1'b0, 8'h3C, 1'b1, 1'b0};
        vt[7] = '{1'b1, 8'h77, 1'b1, 1'b0, 5'd1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 8'h77, 1'b1, 1'b0};
        vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0};

        // Vector table: latency, pop, underflow, mixed traffic.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vt[i].wr, vt[i].wd, vt[i].rd);
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].ec));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].ef));
            chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vt[i].eu));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].eo));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vt[i].edat));
            end
        end
        step(1'b0, 8'h00, 1'b0);

        // Fill: 17 pushes reach full (16 in RAM plus the head word).
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
        chk("fill_count", 32'(count), 32'd17);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_overflow", 32'(overflow), 32'd0);
        step(1'b1, 8'h99, 1'b0);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd17);
        chk("ovf_full", 32'(full), 32'd1);

        // Drain: one word per cycle with no bubble; the dropped 8'h99 never appears.
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("drain%0d_rd_valid", k), 32'(rd_valid), 32'd1);
            chk($sformatf("drain%0d_rd_data", k), 32'(rd_data), 32'(k));
            step(1'b0, 8'h00, 1'b1);
            if (k == 0) begin
                chk("drain_full_cleared", 32'(full), 32'd0);
            end
        end
        chk("drain_rd_valid", 32'(rd_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_full", 32'(full), 32'd0);
        chk("drain_underflow", 32'(underflow), 32'd0);
        step(1'b0, 8'h00, 1'b0);

        // Streaming: preload 3 words, then push and pop together for 100 cycles.
        step(1'b1, 8'd200, 1'b0);
        step(1'b1, 8'd201, 1'b0);
        step(1'b1, 8'd202, 1'b0);
        chk("pre_count", 32'(count), 32'd3);
        exp_v = 8'd200;
        in_v  = 8'd203;
        for (int c = 0; c < 100; c++) begin
            chk($sformatf("stream%0d_rd_valid", c), 32'(rd_valid), 32'd1);
            chk($sformatf("stream%0d_rd_data", c), 32'(rd_data), 32'(exp_v));
            step(1'b1, in_v, 1'b1);
            chk($sformatf("stream%0d_count", c), 32'(count), 32'd3);
            exp_v = exp_v + 8'd1;
            in_v  = in_v + 8'd1;
        end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("tail%0d_rd_data", c), 32'(rd_data), 32'(exp_v));
            step(1'b0, 8'h00, 1'b1);
            exp_v = exp_v + 8'd1;
        end
        chk("tail_count", 32'(count), 32'd0);
        chk("tail_rd_valid", 32'(rd_valid), 32'd0);
        chk("tail_overflow", 32'(overflow), 32'd1);

        // Asynchronous reset mid-stream with count=5 and both sticky flags set.
        step(1'b0, 8'h00, 1'b1);
        chk("pre_rst_underflow", 32'(underflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_full", 32'(full), 32'd0);
        chk("async_overflow", 32'(overflow), 32'd0);
        chk("async_underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        chk("post_rst_lat_rd_valid", 32'(rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_rd_valid", 32'(rd_valid), 32'd1);
        chk("post_rst_rd_data", 32'(rd_data), 32'h3C);
        chk("post_rst_count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
